// File: rtl/led_seq_pkg.sv
// Shared constants for the LED sequencer: register offsets, display modes and FSM states.
package led_seq_pkg;

    localparam logic [1:0] REG_PAT_LO = 2'd0;
    localparam logic [1:0] REG_PAT_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RATE   = 2'd3;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_ROL    = 2'b10;
    localparam logic [1:0] MODE_ROR    = 2'b11;

    typedef enum logic [1:0] {
        StOff,
        StShow,
        StBlank
    } state_e;

    // CTRL bits [6:2] are not stored and always read back as zero.
    function automatic logic [7:0] ctrl_readback(input logic en, input logic [1:0] mode);
        return {en, 5'b00000, mode};
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Prescaler plus rate counter: emits a one-cycle step every (rate+1) prescaler ticks.
module led_step_timer #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clear,
    input  logic       run,
    input  logic [7:0] rate,
    output logic       step
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [7:0]    cnt_q;
    logic [7:0]    cur_rate_q;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);
    assign step = run && !clear && tick && (cnt_q == cur_rate_q);

    // The rate in use is only re-sampled on a wrap or restart, so a RATE write
    // never truncates or stretches the step period already in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            cur_rate_q <= '0;
        end else if (clear || !run) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            cur_rate_q <= rate;
        end else if (tick) begin
            presc_q <= '0;
            if (cnt_q == cur_rate_q) begin
                cnt_q      <= '0;
                cur_rate_q <= rate;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/led_sequencer_ctrl.sv
// Bus-mapped LED sequencer: register file, read-back bus driver and SHOW/BLANK/OFF display FSM.
module led_sequencer_ctrl
    import led_seq_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hC0,
    parameter int unsigned TICK_DIV  = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    output logic [15:0] LED_OUT,
    output logic        STEP
);

    logic [7:0]  offset;
    logic [1:0]  reg_sel;
    logic        hit;
    logic        wr_en;
    logic        rd_en;
    logic        wr_reload;

    logic [7:0]  pat_lo_q;
    logic [7:0]  pat_hi_q;
    logic        en_q;
    logic [1:0]  mode_q;
    logic [7:0]  rate_q;
    logic        rd_valid_q;
    logic [7:0]  rd_data_q;
    logic [7:0]  rd_mux;
    logic        reload_q;

    state_e      state_q;
    logic [15:0] work_q;
    logic [15:0] led_q;
    logic [15:0] work_rol;
    logic [15:0] work_ror;
    logic        step;

    assign offset    = BUS_ADDR - BASE_ADDR;
    assign hit       = (offset[7:2] == 6'd0);
    assign reg_sel   = offset[1:0];
    assign wr_en     = hit && BUS_WE;
    assign rd_en     = hit && !BUS_WE;
    assign wr_reload = wr_en && (reg_sel != REG_RATE);

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            REG_PAT_LO: rd_mux = pat_lo_q;
            REG_PAT_HI: rd_mux = pat_hi_q;
            REG_CTRL:   rd_mux = ctrl_readback(en_q, mode_q);
            REG_RATE:   rd_mux = rate_q;
        endcase
    end

    assign BUS_DATA = rd_valid_q ? rd_data_q : 8'hzz;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pat_lo_q   <= '0;
            pat_hi_q   <= '0;
            en_q       <= 1'b0;
            mode_q     <= MODE_STATIC;
            rate_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            reload_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_sel)
                    REG_PAT_LO: pat_lo_q <= BUS_DATA;
                    REG_PAT_HI: pat_hi_q <= BUS_DATA;
                    REG_CTRL: begin
                        en_q   <= BUS_DATA[7];
                        mode_q <= BUS_DATA[1:0];
                    end
                    REG_RATE:   rate_q <= BUS_DATA;
                endcase
            end
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_mux;
            // Reload lands one edge after the write so it sees the post-write registers.
            reload_q   <= wr_reload;
        end
    end

    // Counters restart across both the write cycle and the reload cycle; any
    // step falling in either is discarded.
    led_step_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (wr_reload || reload_q),
        .run   (state_q != StOff),
        .rate  (rate_q),
        .step  (step)
    );

    assign work_rol = {work_q[14:0], work_q[15]};
    assign work_ror = {work_q[0], work_q[15:1]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StOff;
            work_q  <= '0;
            led_q   <= '0;
        end else if (reload_q) begin
            work_q <= {pat_hi_q, pat_lo_q};
            if (en_q) begin
                state_q <= StShow;
                led_q   <= {pat_hi_q, pat_lo_q};
            end else begin
                state_q <= StOff;
                led_q   <= '0;
            end
        end else if (step) begin
            case (state_q)
                StShow: begin
                    case (mode_q)
                        MODE_STATIC: ;
                        MODE_BLINK: begin
                            state_q <= StBlank;
                            led_q   <= '0;
                        end
                        MODE_ROL: begin
                            work_q <= work_rol;
                            led_q  <= work_rol;
                        end
                        MODE_ROR: begin
                            work_q <= work_ror;
                            led_q  <= work_ror;
                        end
                    endcase
                end
                StBlank: begin
                    state_q <= StShow;
                    led_q   <= work_q;
                end
                default: ;
            endcase
        end
    end

    assign LED_OUT = led_q;
    assign STEP    = step;

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Directed bench for led_sequencer_ctrl with TICK_DIV=4; inputs change on the falling edge.
module tb_led_sequencer_ctrl;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] led;
        logic        step;
        logic [7:0]  bus;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    wire  [7:0]  bus_data;
    logic [7:0]  bus_addr;
    logic [7:0]  tb_drv;
    logic        bus_we;
    logic        tb_oe;
    logic [15:0] led_out;
    logic        step;
    int          total = 0;
    int          bad = 0;
    vec_t        vt [0:17];

    always #5 CLK = ~CLK;

    assign bus_data = tb_oe ? tb_drv : 8'hzz;

    // Released bus reads back as 8'hFF.
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu_i (bus_data[i]);
    end

    led_sequencer_ctrl #(
        .BASE_ADDR(8'hC0),
        .TICK_DIV (4)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BUS_DATA(bus_data),
        .BUS_ADDR(bus_addr),
        .BUS_WE  (bus_we),
        .LED_OUT (led_out),
        .STEP    (step)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] d);
        bus_we   = we;
        bus_addr = a;
        tb_drv   = d;
        tb_oe    = we;
        #1;
    endtask

    task automatic next_cyc();
        @(negedge CLK);
    endtask

    task automatic expect_cyc(input string name, input logic [15:0] led, input logic st);
        chk({name, " led"}, led_out, led);
        chk({name, " step"}, {15'b0, step}, {15'b0, st});
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
        drive(1'b0, a, 8'h00);
        next_cyc();
        drive(1'b0, 8'h00, 8'h00);
        chk(name, {8'h00, bus_data}, {8'h00, exp});
        next_cyc();
        drive(1'b0, 8'h00, 8'h00);
        chk({name, " release"}, {8'h00, bus_data}, 16'h00FF);
        next_cyc();
    endtask

    initial begin
        logic [15:0] rp;
        logic [15:0] el;

        // Reset read-back, then static show: three writes (CTRL last = cycle w), then w+1..w+9.
        vt[0]  = '{1'b0, 8'hC0, 8'h00, 16'h0000, 1'b0, 8'hFF};
        vt[1]  = '{1'b0, 8'hC1, 8'h00, 16'h0000, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 8'hC2, 8'h00, 16'h0000, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 8'hC3, 8'h00, 16'h0000, 1'b0, 8'h00};
        vt[4]  = '{1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'hFF};
        vt[6]  = '{1'b1, 8'hC0, 8'h5A, 16'h0000, 1'b0, 8'h5A};
        vt[7]  = '{1'b1, 8'hC1, 8'hA5, 16'h0000, 1'b0, 8'hA5};
        vt[8]  = '{1'b1, 8'hC2, 8'h80, 16'h0000, 1'b0, 8'h80};
        vt[9]  = '{1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'hFF};
        vt[10] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b0, 8'hFF};
        vt[11] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b0, 8'hFF};
        vt[12] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b0, 8'hFF};
        vt[13] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b1, 8'hFF};
        vt[14] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b0, 8'hFF};
        vt[15] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b0, 8'hFF};
        vt[16] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b0, 8'hFF};
        vt[17] = '{1'b0, 8'h00, 8'h00, 16'hA55A, 1'b1, 8'hFF};

        RESET = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        repeat (3) next_cyc();
        RESET = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].we, vt[i].addr, vt[i].data);
            chk($sformatf("vec%0d led", i), led_out, vt[i].led);
            chk($sformatf("vec%0d step", i), {15'b0, step}, {15'b0, vt[i].step});
            chk($sformatf("vec%0d bus", i), {8'h00, bus_data}, {8'h00, vt[i].bus});
            next_cyc();
        end

        // Remaining 18 ticks of static mode: step every 4th cycle, pattern held.
        for (int k = 0; k < 72; k++) begin
            drive(1'b0, 8'h00, 8'h00);
            expect_cyc("static", 16'hA55A, (k % 4) == 3);
            next_cyc();
        end
        read_chk(8'hC0, 8'h5A, "rd pat_lo");
        read_chk(8'hC1, 8'hA5, "rd pat_hi");
        read_chk(8'hC2, 8'h80, "rd ctrl");
        read_chk(8'hC3, 8'h00, "rd rate");

        // Blink, RATE=1: 8-cycle phases, first toggle 9 edges after the CTRL write edge.
        drive(1'b1, 8'hC0, 8'hFF); next_cyc();
        drive(1'b1, 8'hC1, 8'h00); next_cyc();
        drive(1'b1, 8'hC3, 8'h01); next_cyc();
        drive(1'b1, 8'hC2, 8'h81); next_cyc();
        for (int c = 1; c <= 40; c++) begin
            drive(1'b0, 8'h00, 8'h00);
            el = (c < 2 || (((c - 2) / 8) % 2) == 0) ? 16'h00FF : 16'h0000;
            expect_cyc($sformatf("blink c%0d", c), el, c >= 9 && ((c - 9) % 8) == 0);
            next_cyc();
        end

        // Rotate left, RATE=0: 16 steps bring 8001 back.
        drive(1'b1, 8'hC0, 8'h01); next_cyc();
        drive(1'b1, 8'hC1, 8'h80); next_cyc();
        drive(1'b1, 8'hC3, 8'h00); next_cyc();
        drive(1'b1, 8'hC2, 8'h82); next_cyc();
        rp = 16'h8001;
        for (int c = 1; c <= 69; c++) begin
            if (c >= 6 && ((c - 6) % 4) == 0) rp = {rp[14:0], rp[15]};
            drive(1'b0, 8'h00, 8'h00);
            expect_cyc($sformatf("rol c%0d", c), rp, c >= 5 && ((c - 5) % 4) == 0);
            if (c == 6)  chk("rol first", led_out, 16'h0003);
            if (c == 10) chk("rol second", led_out, 16'h0006);
            if (c == 69) chk("rol wrap", led_out, 16'h8001);
            next_cyc();
        end

        // PAT_LO write lands on the cycle a step is due (c=73): reload wins.
        for (int c = 70; c <= 72; c++) begin
            drive(1'b0, 8'h00, 8'h00);
            expect_cyc("pre-collision", 16'h0003, 1'b0);
            next_cyc();
        end
        drive(1'b1, 8'hC0, 8'h0F);
        expect_cyc("collision", 16'h0003, 1'b0);
        next_cyc();
        for (int c = 74; c <= 79; c++) begin
            drive(1'b0, 8'h00, 8'h00);
            el = (c == 74) ? 16'h0003 : ((c == 79) ? 16'h001F : 16'h800F);
            expect_cyc($sformatf("post-collision c%0d", c), el, c == 78);
            next_cyc();
        end

        // Disable mid-blink with junk in CTRL[6:2].
        drive(1'b1, 8'hC2, 8'h81); next_cyc();
        drive(1'b0, 8'h00, 8'h00); next_cyc();
        drive(1'b0, 8'h00, 8'h00);
        expect_cyc("blink2 show", 16'h800F, 1'b0);
        next_cyc();
        drive(1'b1, 8'hC2, 8'h7D);
        expect_cyc("disable wr", 16'h800F, 1'b0);
        next_cyc();
        drive(1'b0, 8'h00, 8'h00);
        expect_cyc("disable reload", 16'h800F, 1'b0);
        next_cyc();
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 8'h00, 8'h00);
            expect_cyc("disabled", 16'h0000, 1'b0);
            next_cyc();
        end
        read_chk(8'hC2, 8'h01, "rd ctrl masked");

        // Re-enable blink (RATE=0), then reset in the middle of BLANK.
        drive(1'b1, 8'hC2, 8'h81); next_cyc();
        drive(1'b0, 8'h00, 8'h00); next_cyc();
        for (int c = 2; c <= 6; c++) begin
            drive(1'b0, 8'h00, 8'h00);
            expect_cyc($sformatf("reen c%0d", c), (c == 6) ? 16'h0000 : 16'h800F, c == 5);
            next_cyc();
        end
        RESET = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        expect_cyc("blank before reset", 16'h0000, 1'b0);
        next_cyc();
        RESET = 1'b0;
        for (int c = 8; c <= 11; c++) begin
            drive(1'b0, 8'h00, 8'h00);
            expect_cyc($sformatf("after reset c%0d", c), 16'h0000, 1'b0);
            next_cyc();
        end
        read_chk(8'hC0, 8'h00, "rst pat_lo");
        read_chk(8'hC1, 8'h00, "rst pat_hi");
        read_chk(8'hC2, 8'h00, "rst ctrl");
        read_chk(8'hC3, 8'h00, "rst rate");
        chk("rst led", led_out, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
